// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared UART TX state encoding and line-level bit constants.
//            STOP2 is present only when UART_TX_TWO_STOP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
`endif

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : Payload store register and LSB-first bit selection for UART TX.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] store,
    output logic                  next_bit,
    output logic                  last
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] peek_idx;

    assign last     = (bit_cnt == LAST_IDX);
    assign cnt_inc  = last ? '0 : bit_cnt + 1'b1;
    // The output register captures the bit that will be on the line next cycle.
    assign peek_idx = shift_en ? cnt_inc : bit_cnt;
    assign next_bit = store[peek_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            store   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            store   <= din;
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= cnt_inc;
        end
    end

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/uart_tx_fsm_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fsm_serializer
// Purpose  : UART transmit FSM, one bit per CLK, optional parity bit.
//            Define UART_TX_TWO_STOP_EN for a second stop bit (STOP2).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fsm_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic [DATA_WIDTH-1:0] store,
    output logic                  busy,
    output logic                  TX_OUT
);

    tx_state_t state;
    logic      par_en_q;
    logic      par_q;
    logic      load;
    logic      shift_en;
    logic      ser_bit;
    logic      ser_last;

    assign load     = (state == IDLE) && Data_Valid;
    assign shift_en = (state == DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .shift_en (shift_en),
        .din      (P_DATA),
        .store    (store),
        .next_bit (ser_bit),
        .last     (ser_last)
    );

    // Outputs are registered from the next state, so TX_OUT/busy align with state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            TX_OUT   <= STOP_BIT;
            busy     <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        state    <= START;
                        TX_OUT   <= START_BIT;
                        busy     <= 1'b1;
                        par_en_q <= PAR_EN;
                    end
                end
                START: begin
                    par_q  <= par_bit;
                    state  <= DATA;
                    TX_OUT <= ser_bit;
                end
                DATA: begin
                    if (!ser_last) begin
                        TX_OUT <= ser_bit;
                    end else if (par_en_q) begin
                        state  <= PARITY;
                        TX_OUT <= par_q;
                    end else begin
                        state  <= STOP;
                        TX_OUT <= STOP_BIT;
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= STOP_BIT;
                end
`ifdef UART_TX_TWO_STOP_EN
                STOP: begin
                    state  <= STOP2;
                    TX_OUT <= STOP_BIT;
                end
                STOP2: begin
                    state  <= IDLE;
                    TX_OUT <= STOP_BIT;
                    busy   <= 1'b0;
                end
`else
                STOP: begin
                    state  <= IDLE;
                    TX_OUT <= STOP_BIT;
                    busy   <= 1'b0;
                end
`endif
                default: begin
                    state  <= IDLE;
                    TX_OUT <= STOP_BIT;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_tx_fsm_serializer
`default_nettype wire

// File: tb/tb_uart_tx_fsm_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fsm_serializer
// Purpose  : Directed self-checking bench for uart_tx_fsm_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fsm_serializer;

`ifdef UART_TX_TWO_STOP_EN
    localparam int TWO_STOP = 1;
`else
    localparam int TWO_STOP = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       par_bit;
    logic [7:0] store;
    logic       busy;
    logic       TX_OUT;
    logic       odd_mode;

    int total = 0;
    int bad   = 0;

    uart_tx_fsm_serializer #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .store      (store),
        .busy       (busy),
        .TX_OUT     (TX_OUT)
    );

    // Downstream parity calculator, even or odd
    assign par_bit = odd_mode ? ~(^store) : (^store);

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp_bits[i] is the line value in frame cycle i; upper bits padded with 1.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic [15:0] exp_bits, input int base_len,
                             input int dv_at, input logic [7:0] dv_data);
        int len;
        len        = base_len + TWO_STOP;
        P_DATA     = d;
        PAR_EN     = pe;
        Data_Valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge CLK);
            Data_Valid = 1'b0;
            chk({tag, "_tx"},    {31'd0, TX_OUT}, {31'd0, exp_bits[i]});
            chk({tag, "_busy"},  {31'd0, busy},   32'd1);
            chk({tag, "_store"}, {24'd0, store},  {24'd0, d});
            if (i == dv_at) begin
                Data_Valid = 1'b1;
                P_DATA     = dv_data;
            end
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        chk({tag, "_end_busy"}, {31'd0, busy},   32'd0);
        chk({tag, "_end_tx"},   {31'd0, TX_OUT}, 32'd1);
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        odd_mode   = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_tx",    {31'd0, TX_OUT}, 32'd1);
        chk("rst_busy",  {31'd0, busy},   32'd0);
        chk("rst_store", {24'd0, store},  32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
        run_frame("a5_even", 8'hA5, 1'b1, 16'hFD4A, 11, -1, 8'h00);
        // Back-to-back after a single idle cycle, no parity: 0,0,0,1,1,1,1,0,0,1
        run_frame("3c_nopar", 8'h3C, 1'b0, 16'hFE78, 10, -1, 8'h00);
        // 0x01 odd parity: parity bit 0
        odd_mode = 1'b1;
        run_frame("01_odd", 8'h01, 1'b1, 16'hFC02, 11, -1, 8'h00);
        odd_mode = 1'b0;
        // Data_Valid with 0xFF during the 4th DATA cycle of a 0x00 frame
        run_frame("00_dv", 8'h00, 1'b0, 16'hFE00, 10, 4, 8'hFF);
        @(negedge CLK);
        chk("no_second_busy",  {31'd0, busy},   32'd0);
        chk("no_second_tx",    {31'd0, TX_OUT}, 32'd1);
        chk("no_second_store", {24'd0, store},  32'd0);

        // Reset in the 3rd DATA cycle of a 0x5A frame
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b1;
        Data_Valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Data_Valid = 1'b0;
        chk("mid_start", {31'd0, TX_OUT}, 32'd0);
        @(negedge CLK);
        chk("mid_d0", {31'd0, TX_OUT}, 32'd0);
        @(negedge CLK);
        chk("mid_d1", {31'd0, TX_OUT}, 32'd1);
        @(negedge CLK);
        chk("mid_d2", {31'd0, TX_OUT}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_tx",    {31'd0, TX_OUT}, 32'd1);
        chk("mid_rst_busy",  {31'd0, busy},   32'd0);
        chk("mid_rst_store", {24'd0, store},  32'd0);

        // Data_Valid together with RST is ignored
        Data_Valid = 1'b1;
        P_DATA     = 8'hA5;
        @(negedge CLK);
        RST        = 1'b0;
        Data_Valid = 1'b0;
        chk("dv_rst_busy",  {31'd0, busy},  32'd0);
        chk("dv_rst_store", {24'd0, store}, 32'd0);
        @(negedge CLK);
        chk("dv_rst_idle_busy", {31'd0, busy},   32'd0);
        chk("dv_rst_idle_tx",   {31'd0, TX_OUT}, 32'd1);

        // Full frame after reset
        run_frame("a5_after_rst", 8'hA5, 1'b1, 16'hFD4A, 11, -1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx_fsm_serializer
`default_nettype wire

// File: doc/uart_tx_fsm_serializer.md
UART_TX_FSM_SERIALIZER -- requirements
Module: uart_tx_fsm_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 SHALL have port CLK, input, 1, the single bit-rate clock; one serial bit is transmitted per CLK cycle.
REQ-003 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH, the parallel payload to send.
REQ-005 SHALL have port Data_Valid, input, 1, a one-cycle request qualifying P_DATA.
REQ-006 SHALL have port PAR_EN, input, 1; 1 inserts a parity bit.
REQ-007 SHALL have port par_bit, input, 1, the parity result from the downstream parity calculator computed from store.
REQ-008 SHALL have port store, output, DATA_WIDTH, the latched payload fed to the parity calculator.
REQ-009 SHALL have port busy, output, 1, high while a frame is on the line.
REQ-010 SHALL have port TX_OUT, output, 1, the registered serial line, idle high.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY and STOP, plus STOP2 under REQ-024.
REQ-012 SHALL accept Data_Valid only in IDLE; on the accept edge it latches P_DATA into store and PAR_EN internally, then enters START.
REQ-013 SHALL ignore Data_Valid in every state other than IDLE, with no queuing and no change to store.
REQ-014 SHALL drive TX_OUT=0 in START, then DATA_WIDTH DATA cycles LSB first (store[0] first), using a bit counter of width $clog2(DATA_WIDTH) that wraps from DATA_WIDTH-1 to exit.
REQ-015 SHALL register par_bit internally during START and drive that registered value in PARITY; the transition is DATA->PARITY when latched PAR_EN=1, otherwise DATA->STOP.
REQ-016 SHALL drive TX_OUT=1 in STOP, then return to IDLE; a Data_Valid arriving in the IDLE cycle after STOP starts a new frame, so the minimum inter-frame gap is 1 idle cycle.
REQ-017 SHALL register TX_OUT and busy, with busy=1 in all non-IDLE states and busy=0 in IDLE.
REQ-018 SHALL give a latency of exactly one cycle from the Data_Valid accept edge to the START bit on TX_OUT.
REQ-019 SHALL have a frame length of 1+DATA_WIDTH+PAR_EN+1 cycles, or +1 under REQ-024.
REQ-020 SHALL keep store constant from the accept edge through STOP, so par_bit is stable.
REQ-021 SHALL not let changes on PAR_EN or P_DATA mid-frame affect the current frame.

Reset
REQ-022 SHALL, while RST=1 at a CLK edge, set the state to IDLE, TX_OUT=1, busy=0, store=0, the bit counter to 0, and the latched PAR_EN and parity bits to 0.
REQ-023 SHALL treat reset mid-frame as abandoning the frame, with the line high on the next edge; Data_Valid asserted together with RST is ignored.

Configuration
REQ-024 SHALL, when macro UART_TX_TWO_STOP_EN is defined, add state STOP2 after STOP, driving TX_OUT=1 for a second stop cycle before IDLE; when the macro is undefined, STOP2 and its logic SHALL not exist and STOP goes directly to IDLE.

Structure
REQ-025 SHALL take the state encoding type and the constants START_BIT=0 and STOP_BIT=1 from shared package uart_tx_pkg, which is also used by the mux and parity stages.
REQ-026 SHALL place the store register and bit-select logic in sub-module uart_tx_serializer, controlled by a load/shift-enable from the FSM; the FSM and output register stay in the top module.

Verification
REQ-027 SHALL cover: P_DATA=0xA5, PAR_EN=1, even-parity calculator -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, with busy high for exactly 11 cycles.
REQ-028 SHALL cover: P_DATA=0x01, PAR_EN=1, odd parity -> parity cycle TX_OUT=0, frame of 11 cycles.
REQ-029 SHALL cover: P_DATA=0x3C, PAR_EN=0 -> TX_OUT = 0,0,0,1,1,1,1,0,0,1 over 10 cycles with no parity cycle.
REQ-030 SHALL cover: Data_Valid with 0xFF in the 4th DATA cycle of a 0x00 frame -> frame stays all-zero data, store stays 0x00, and no second frame starts.
REQ-031 SHALL cover: RST=1 in the 3rd DATA cycle -> next edge TX_OUT=1, busy=0, store=0x00; a new Data_Valid after reset produces a complete correct frame.
REQ-032 SHALL cover: with UART_TX_TWO_STOP_EN defined, 0xA5 with parity -> 12-cycle frame ending 1,1; without the macro the same stimulus gives 11 cycles.
